// File: rtl/priority_dc_pkg.sv
// +----------------------------------------------------------------------+
// | priority_dc_pkg: shared types and the index-to-one-hot helper for    |
// | the frame-accumulating index decoder.                                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package priority_dc_pkg;

  localparam int c_MAX_VEC_WIDTH = 64;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } dc_state_e;

  // Returns all zeros when idx is outside [0, width)
  function automatic logic [c_MAX_VEC_WIDTH-1:0] onehot_dec(input int idx, input int width);
    logic [c_MAX_VEC_WIDTH-1:0] v;
    v = '0;
    if (idx >= 0 && idx < width && idx < c_MAX_VEC_WIDTH) v[idx] = 1'b1;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/idx_onehot_dec.sv
// +----------------------------------------------------------------------+
// | idx_onehot_dec: combinational index decoder with range flag.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module idx_onehot_dec
  import priority_dc_pkg::*;
#(
  parameter  int VEC_WIDTH = 4,
  localparam int IDX_WIDTH = $clog2(VEC_WIDTH)
) (
  input  logic [IDX_WIDTH-1:0] idx,
  output logic [VEC_WIDTH-1:0] vec,
  output logic                 in_range
);

  logic [c_MAX_VEC_WIDTH-1:0] w_full;

  assign w_full   = onehot_dec(32'(idx), VEC_WIDTH);
  assign vec      = w_full[VEC_WIDTH-1:0];
  // The decode is empty exactly when the index is out of range
  assign in_range = |vec;

  generate
    if (VEC_WIDTH < c_MAX_VEC_WIDTH) begin : g_unused_hi
      logic w_unused_hi;
      assign w_unused_hi = ^w_full[c_MAX_VEC_WIDTH-1:VEC_WIDTH];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/priority_dc_acc.sv
// +----------------------------------------------------------------------+
// | priority_dc_acc: ORs a stream of index beats into a vector per frame;|
// | optional descending-order check via PRIORITY_DC_ORDER_CHECK_EN.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module priority_dc_acc
  import priority_dc_pkg::*;
#(
  parameter  int VEC_WIDTH = 4,
  localparam int IDX_WIDTH = $clog2(VEC_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IDX_WIDTH-1:0] in_idx,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [VEC_WIDTH-1:0] out_vec,
  output logic                 out_err
);

  dc_state_e            r_state;
  dc_state_e            w_state_nxt;
  logic [VEC_WIDTH-1:0] r_acc;
  logic                 r_ferr;
  logic                 r_out_valid;
  logic [VEC_WIDTH-1:0] r_out_vec;
  logic                 r_out_err;

  logic [VEC_WIDTH-1:0] w_vec;
  logic                 w_in_range;
  logic                 w_accept;
  logic                 w_order_err;
  logic                 w_beat_err;
  logic [VEC_WIDTH-1:0] w_acc_nxt;

  idx_onehot_dec #(.VEC_WIDTH(VEC_WIDTH)) u_dec (
    .idx      (in_idx),
    .vec      (w_vec),
    .in_range (w_in_range)
  );

  assign in_ready   = !r_out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_acc_nxt  = r_acc | w_vec;
  assign w_beat_err = !w_in_range || (|(r_acc & w_vec)) || w_order_err;

`ifdef PRIORITY_DC_ORDER_CHECK_EN
  logic [IDX_WIDTH-1:0] r_prev_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_prev_idx <= '0;
    else if (w_accept) r_prev_idx <= in_last ? '0 : in_idx;
  end

  // Iterated MSB-priority encoding yields strictly descending indices
  assign w_order_err = (r_state == ACC) && !(in_idx < r_prev_idx);
`else
  assign w_order_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) w_state_nxt = in_last ? IDLE : ACC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_ferr <= 1'b0;
    end else if (w_accept) begin
      r_acc  <= in_last ? '0   : w_acc_nxt;
      r_ferr <= in_last ? 1'b0 : (r_ferr || w_beat_err);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_vec   <= '0;
      r_out_err   <= 1'b0;
    end else if (w_accept && in_last) begin
      r_out_valid <= 1'b1;
      r_out_vec   <= w_acc_nxt;
      r_out_err   <= r_ferr || w_beat_err;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_vec   = r_out_vec;
  assign out_err   = r_out_err;

endmodule

`default_nettype wire
